// File: rtl/wide_add_scheduler.sv
// wide_add_scheduler: arbitrates two requesters onto one external 32-bit adder
// and computes a WORDS*32-bit add or subtract one slice per cycle, LSB first.
//
// Ports:
//   Clk, Rst                     clock, synchronous active-high reset
//   Req{0,1}Valid/Ready          request handshake (Ready combinational, IDLE only)
//   Req{0,1}A/B/Sub              operands and op select (1 = A-B)
//   RespValid/RespReady          result handshake, result held until accepted
//   RespId/Sum/Cout/Ovf          requester id, result, final carry, signed overflow
//   AddA/AddB/AddCin -> AddS/AddCout   shared combinational adder slice
//   Busy                         high whenever not IDLE
module wide_add_scheduler #(
    parameter int unsigned WORDS = 4
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Req0Valid,
    output logic                  Req0Ready,
    input  logic [32*WORDS-1:0]   Req0A,
    input  logic [32*WORDS-1:0]   Req0B,
    input  logic                  Req0Sub,
    input  logic                  Req1Valid,
    output logic                  Req1Ready,
    input  logic [32*WORDS-1:0]   Req1A,
    input  logic [32*WORDS-1:0]   Req1B,
    input  logic                  Req1Sub,
    output logic                  RespValid,
    input  logic                  RespReady,
    output logic                  RespId,
    output logic [32*WORDS-1:0]   RespSum,
    output logic                  RespCout,
    output logic                  RespOvf,
    output logic [31:0]           AddA,
    output logic [31:0]           AddB,
    output logic                  AddCin,
    input  logic [31:0]           AddS,
    input  logic                  AddCout,
    output logic                  Busy
);

    localparam int unsigned KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [WORDS-1:0][31:0] a_q, b_q, sum_q;
    logic                   sub_q, carry_q, prio_q;
    logic [KW-1:0]          k_q;
    logic                   hs0, hs1, ovf_c;

    assign hs0     = Req0Valid && Req0Ready;
    assign hs1     = Req1Valid && Req1Ready;
    assign RespSum = sum_q;

    // Overflow from the top slice: operands agree in sign, result sign differs.
    assign ovf_c = (AddA[31] == AddB[31]) && (AddS[31] != AddA[31]);

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, grant and adder drive.
    always_comb begin
        state_d   = state_q;
        Req0Ready = 1'b0;
        Req1Ready = 1'b0;
        AddA      = '0;
        AddB      = '0;
        AddCin    = 1'b0;
        case (state_q)
            IDLE: begin
                // Prio only breaks ties; a lone valid requester always wins.
                if (!Rst) begin
                    Req0Ready = Req0Valid && (!Req1Valid || !prio_q);
                    Req1Ready = Req1Valid && (!Req0Valid || prio_q);
                end
                if (Req0Ready || Req1Ready) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                AddA   = a_q[k_q];
                AddB   = sub_q ? ~b_q[k_q] : b_q[k_q];
                AddCin = (k_q == '0) ? sub_q : carry_q;
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (RespReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, slice accumulation and registered response flags.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            sub_q     <= 1'b0;
            carry_q   <= 1'b0;
            prio_q    <= 1'b0;
            k_q       <= '0;
            RespValid <= 1'b0;
            RespId    <= 1'b0;
            RespCout  <= 1'b0;
            RespOvf   <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            RespValid <= (state_d == DONE);
            Busy      <= (state_d != IDLE);
            if (hs0 || hs1) begin
                a_q    <= hs1 ? Req1A : Req0A;
                b_q    <= hs1 ? Req1B : Req0B;
                sub_q  <= hs1 ? Req1Sub : Req0Sub;
                k_q    <= '0;
                prio_q <= hs0;
                RespId <= hs1;
            end
            if (state_q == RUN) begin
                sum_q[k_q] <= AddS;
                carry_q    <= AddCout;
                k_q        <= k_q + KW'(1);
                if (k_q == K_LAST) begin
                    RespCout <= AddCout;
                    RespOvf  <= ovf_c;
                end
            end
        end
    end

endmodule
